// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_state_t;

   localparam int MAX_WIDTH = 64;

   // Difference bit of a 1-bit full subtractor
   function automatic logic fs_diff(input logic a, input logic b, input logic br);
      return a ^ b ^ br;
   endfunction

   // Borrow-out of a 1-bit full subtractor
   function automatic logic fs_borrow(input logic a, input logic b, input logic br);
      return (~a & b) | (~(a ^ b) & br);
   endfunction

endpackage

// File: rtl/serial_subtractor_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout = borrow-out.
module full_subtractor_cell
   import serial_subtractor_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = fs_diff(a, b, bin);
   assign bout = fs_borrow(a, b, bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: c = (a - b) mod 2^WIDTH, one bit per clock, LSB first.
// Optional SERIAL_SUBTRACTOR_OVFL_EN adds the signed-overflow output ovfl.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 4
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] c,
   output logic             borrow
`ifdef SERIAL_SUBTRACTOR_OVFL_EN
   ,
   output logic             ovfl
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   sub_state_t       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] r_sh;   // partial result, kept internal so c never shows a partial value
   logic [WIDTH-1:0] r_next;
   logic [WIDTH-1:0] d_msb;
   logic             br;
   logic [CW-1:0]    cnt;
   logic             d;
   logic             br_next;

   full_subtractor_cell u_cell (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (br),
      .d    (d),
      .bout (br_next)
   );

   // New difference bit enters the result from the MSB side
   always_comb begin
      d_msb            = '0;
      d_msb[WIDTH-1]   = d;
      r_next           = (r_sh >> 1) | d_msb;
   end

   // Handshake FSM, operand shifters, bit counter and registered result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
         r_sh      <= '0;
         br        <= 1'b0;
         cnt       <= '0;
         c         <= '0;
         borrow    <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVFL_EN
         ovfl      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  a_sh     <= a;
                  b_sh     <= b;
                  r_sh     <= '0;
                  br       <= 1'b0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               r_sh <= r_next;
               br   <= br_next;
               cnt  <= cnt + CW'(1);
               if (cnt == LAST) begin
                  c         <= r_next;
                  borrow    <= br_next;
`ifdef SERIAL_SUBTRACTOR_OVFL_EN
                  // operand MSBs sit in bit 0 of the shifters on the last bit
                  ovfl      <= (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ d);
`endif
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed table and corner sequences on a
// WIDTH=4 instance, plus random sweeps at WIDTH=1, 4 and 8.
`timescale 1ns/1ps
module tb_serial_subtractor;

   localparam int NOPS = 1000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values
   function automatic void model(input int w, input longint x, input longint y,
                                 output longint ec, output longint eb, output longint eo);
      longint m, sx, sy, sd;
      m  = longint'(1) << w;
      ec = (x - y + m) % m;
      eb = (x < y) ? 1 : 0;
      sx = (x >= m / 2) ? x - m : x;
      sy = (y >= m / 2) ? y - m : y;
      sd = sx - sy;
      eo = (sd < -(m / 2) || sd >= m / 2) ? 1 : 0;
   endfunction

   // ---------------- directed WIDTH=4 instance ----------------
   logic       rst_n, in_valid, in_ready, out_valid, out_ready, borrow, ovfl;
   logic [3:0] a, b, c;

   serial_subtractor #(.WIDTH(4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c),
      .borrow    (borrow)
`ifdef SERIAL_SUBTRACTOR_OVFL_EN
      ,
      .ovfl      (ovfl)
`endif
   );
`ifndef SERIAL_SUBTRACTOR_OVFL_EN
   assign ovfl = 1'b0;
`endif

   // One full transaction; lat counts cycles from the accept cycle to out_valid
   task automatic op4(input logic [3:0] ia, input logic [3:0] ib,
                      output logic [3:0] oc, output logic ob, output logic oo, output int lat);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      if (!in_ready) chk("op4 in_ready wait", in_ready, 1);
      a = ia; b = ib; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
      oc = c; ob = borrow; oo = ovfl;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] c;
      logic       br;
      logic       ov;
   } vec_t;

   // ---------------- random sweeps ----------------
   for (genvar g = 0; g < 3; g++) begin : g_sw
      localparam int W = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
      logic         rn, iv, ir, ov, orr, brw, ovf, done;
      logic [W-1:0] ra, rb, rc;

      serial_subtractor #(.WIDTH(W)) u_dut (
         .clk       (clk),
         .rst_n     (rn),
         .in_valid  (iv),
         .in_ready  (ir),
         .a         (ra),
         .b         (rb),
         .out_valid (ov),
         .out_ready (orr),
         .c         (rc),
         .borrow    (brw)
`ifdef SERIAL_SUBTRACTOR_OVFL_EN
         ,
         .ovfl      (ovf)
`endif
      );
`ifndef SERIAL_SUBTRACTOR_OVFL_EN
      assign ovf = 1'b0;
`endif

      initial begin
         longint qa[$];
         longint qb[$];
         longint ec, eb, eo;
         int     sent, got, cyc;
         logic   pv;
         sent = 0; got = 0; cyc = 0; pv = 1'b0;
         done = 1'b0; rn = 1'b0; iv = 1'b0; orr = 1'b0; ra = '0; rb = '0;
         repeat (3) @(negedge clk);
         rn = 1'b1;
         while (got < NOPS && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (pv) chk($sformatf("w%0d hold valid", W), ov, 1);
            if (ov) begin
               if (qa.size() == 0) begin
                  chk($sformatf("w%0d spurious valid", W), ov, 0);
               end else begin
                  model(W, qa[0], qb[0], ec, eb, eo);
                  chk($sformatf("w%0d c a=%0d b=%0d", W, qa[0], qb[0]), rc, ec);
                  chk($sformatf("w%0d borrow a=%0d b=%0d", W, qa[0], qb[0]), brw, eb);
`ifdef SERIAL_SUBTRACTOR_OVFL_EN
                  chk($sformatf("w%0d ovfl a=%0d b=%0d", W, qa[0], qb[0]), ovf, eo);
`endif
               end
            end
            orr = ($urandom_range(2) != 0);
            if (ov && orr && qa.size() != 0) begin
               void'(qa.pop_front());
               void'(qb.pop_front());
               got++;
            end
            pv = ov && !orr;
            if (sent < NOPS && $urandom_range(1) == 1) begin
               iv = 1'b1;
               ra = W'($urandom);
               rb = W'($urandom);
               if (ir) begin
                  qa.push_back(longint'(ra));
                  qb.push_back(longint'(rb));
                  sent++;
               end
            end else begin
               iv = 1'b0;
            end
         end
         iv = 1'b0; orr = 1'b0;
         chk($sformatf("w%0d results drained", W), got, NOPS);
         chk($sformatf("w%0d queue empty", W), qa.size(), 0);
         done = 1'b1;
      end
   end

   // ---------------- directed sequences ----------------
   initial begin
      vec_t       tbl[6];
      logic [3:0] rc;
      logic       rb, ro;
      int         lat, n;

      tbl[0] = '{4'd5,  4'd3, 4'd2,  1'b0, 1'b0};
      tbl[1] = '{4'd3,  4'd5, 4'd14, 1'b1, 1'b0};
      tbl[2] = '{4'd15, 4'd15, 4'd0, 1'b0, 1'b0};
      tbl[3] = '{4'd0,  4'd1, 4'd15, 1'b1, 1'b0};
      tbl[4] = '{4'd8,  4'd1, 4'd7,  1'b0, 1'b1};
      tbl[5] = '{4'd7,  4'd8, 4'd15, 1'b1, 1'b1};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      @(negedge clk);
      chk("reset out_valid", out_valid, 0);
      chk("reset in_ready", in_ready, 0);
      chk("reset c", c, 0);
      chk("reset borrow", borrow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (tbl[i]) begin
         op4(tbl[i].a, tbl[i].b, rc, rb, ro, lat);
         chk($sformatf("vec%0d c", i), rc, tbl[i].c);
         chk($sformatf("vec%0d borrow", i), rb, tbl[i].br);
         chk($sformatf("vec%0d latency", i), lat, 5);
`ifdef SERIAL_SUBTRACTOR_OVFL_EN
         chk($sformatf("vec%0d ovfl", i), ro, tbl[i].ov);
`endif
      end

      // reset two cycles into RUN abandons the operation
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      a = 4'd12; b = 4'd6; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrun rst out_valid", out_valid, 0);
      chk("midrun rst c", c, 0);
      chk("midrun rst borrow", borrow, 0);
      chk("midrun rst in_ready", in_ready, 0);
`ifdef SERIAL_SUBTRACTOR_OVFL_EN
      chk("midrun rst ovfl", ovfl, 0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("post rst no valid", out_valid, 0);
      end
      op4(4'd12, 4'd6, rc, rb, ro, lat);
      chk("post rst c", rc, 6);
      chk("post rst borrow", rb, 0);

      // backpressure: result held, new operands refused until back in IDLE
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      a = 4'd9; b = 4'd4; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin @(negedge clk); n++; end
      chk("bp c", c, 5);
      chk("bp borrow", borrow, 0);
      a = 4'd1; b = 4'd1; in_valid = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("bp hold valid", out_valid, 1);
         chk("bp hold c", c, 5);
         chk("bp in_ready low", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp drained valid", out_valid, 0);
      chk("bp idle in_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp accepted", in_ready, 0);
      lat = 1;
      while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
      chk("bp second latency", lat, 5);
      chk("bp second c", c, 0);
      chk("bp second borrow", borrow, 0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      n = 0;
      while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done) && n < 60000) begin
         @(negedge clk);
         n++;
      end
      if (!(g_sw[0].done && g_sw[1].done && g_sw[2].done))
         chk("sweep completion", {g_sw[2].done, g_sw[1].done, g_sw[0].done}, 3'b111);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
